// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing with memory-latency stall.
// Optional trap on undecodable opcodes when LEGV8_ILLEGAL_TRAP_EN is defined.
//
// state    | meaning
// FETCH    | wait for a valid instruction word, load IR and PC+4
// DECODE   | classify the latched opcode, present Read2 select
// EXEC_R   | R-type ALU operation
// WB_R     | write ALU result to the register file
// ADDR     | compute load/store address, arm the latency counter
// MEM_RD   | hold data-memory read until the counter expires
// MEM_WR   | hold data-memory write until the counter expires
// WB_LD    | write memory data to the register file
// BR_CBZ   | conditional branch on Zero
// BR_B     | unconditional branch
// BAD      | undecodable opcode (trap or one-cycle NOP)

module legv8_multicycle_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_im_valid,
    input  logic [10:0]      i_opcode,
    input  logic             i_zero,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_branch,
    output logic             o_uncond_branch,
    output logic             o_reg2loc,
    output logic             o_alu_src,
    output logic [1:0]       o_alu_op,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_LD, S_BR_CBZ, S_BR_B, S_BAD
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [10:0]      r_opcode;
    logic [3:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_instr_count;

    logic w_is_r, w_is_ldur, w_is_stur, w_is_cbz, w_is_b;
    logic w_fetch_go, w_retire;
    logic w_unused_zero;

    // Zero only gates the branch inside the datapath; the sequence never depends on it.
    assign w_unused_zero = i_zero;

    assign w_is_r    = (r_opcode == 11'b10001011000) || (r_opcode == 11'b11001011000) ||
                       (r_opcode == 11'b10001010000) || (r_opcode == 11'b10101010000);
    assign w_is_ldur = (r_opcode == 11'b11111000010);
    assign w_is_stur = (r_opcode == 11'b11111000000);
    assign w_is_cbz  = (r_opcode[10:3] == 8'b10110100);
    assign w_is_b    = (r_opcode[10:5] == 6'b000101);

    assign w_fetch_go = (r_state == S_FETCH) && i_im_valid && !i_rst;
    assign w_retire   = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_comb begin
        w_next          = r_state;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_branch        = 1'b0;
        o_uncond_branch = 1'b0;
        o_reg2loc       = 1'b0;
        o_alu_src       = 1'b0;
        o_alu_op        = 2'b00;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_write     = 1'b0;
        o_illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_go) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                o_reg2loc = w_is_stur || w_is_cbz;
                if (w_is_r)                      w_next = S_EXEC_R;
                else if (w_is_ldur || w_is_stur) w_next = S_ADDR;
                else if (w_is_cbz)               w_next = S_BR_CBZ;
                else if (w_is_b)                 w_next = S_BR_B;
                else                             w_next = S_BAD;
            end
            S_EXEC_R: begin
                o_alu_op = 2'b10;
                w_next   = S_WB_R;
            end
            S_WB_R: begin
                o_alu_op    = 2'b10;
                o_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDR: begin
                o_alu_src = 1'b1;
                w_next    = w_is_ldur ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_alu_src  = 1'b1;
                if (r_wait_cnt == 4'd0) w_next = S_WB_LD;
            end
            S_MEM_WR: begin
                o_mem_write = 1'b1;
                o_alu_src   = 1'b1;
                if (r_wait_cnt == 4'd0) w_next = S_FETCH;
            end
            S_WB_LD: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                w_next       = S_FETCH;
            end
            S_BR_CBZ: begin
                o_reg2loc = 1'b1;
                o_alu_op  = 2'b01;
                o_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BR_B: begin
                o_uncond_branch = 1'b1;
                w_next          = S_FETCH;
            end
            S_BAD: begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
                o_illegal = 1'b1;
                w_next    = S_BAD;
`else
                w_next    = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_FETCH;
            r_opcode      <= 11'd0;
            r_wait_cnt    <= 4'd0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_fetch_go) r_opcode <= i_opcode;
            if (r_state == S_ADDR)
                r_wait_cnt <= LAT_M1;
            else if (((r_state == S_MEM_RD) || (r_state == S_MEM_WR)) && (r_wait_cnt != 4'd0))
                r_wait_cnt <= r_wait_cnt - 4'd1;
            if (w_retire) r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: two instances (MEM_LAT 3 and 1) checked cycle by cycle
// against per-instruction output sequences derived from the opcode class.
module tb_legv8_multicycle_ctrl;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    localparam logic [12:0] O_IR  = 13'h1000;
    localparam logic [12:0] O_PC  = 13'h0800;
    localparam logic [12:0] O_BR  = 13'h0400;
    localparam logic [12:0] O_UB  = 13'h0200;
    localparam logic [12:0] O_R2L = 13'h0100;
    localparam logic [12:0] O_SRC = 13'h0080;
    localparam logic [12:0] O_A10 = 13'h0040;
    localparam logic [12:0] O_A01 = 13'h0020;
    localparam logic [12:0] O_MR  = 13'h0010;
    localparam logic [12:0] O_MW  = 13'h0008;
    localparam logic [12:0] O_M2R = 13'h0004;
    localparam logic [12:0] O_RW  = 13'h0002;
    localparam logic [12:0] O_ILL = 13'h0001;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        zero = 1'b0;
    logic        iv_a = 1'b0, iv_b = 1'b0;
    logic [10:0] op_a = '0, op_b = '0;

    logic        a_ir, a_pc, a_br, a_ub, a_r2l, a_src, a_mr, a_mw, a_m2r, a_rw, a_ill;
    logic [1:0]  a_aop;
    logic [31:0] cnt_a;
    logic        b_ir, b_pc, b_br, b_ub, b_r2l, b_src, b_mr, b_mw, b_m2r, b_rw, b_ill;
    logic [1:0]  b_aop;
    logic [31:0] cnt_b;
    logic [12:0] outs_a, outs_b;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_cnt [2];
    logic [12:0] exp_q [$];

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(.MEM_LAT(LAT_A), .CNT_W(32)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_im_valid(iv_a), .i_opcode(op_a), .i_zero(zero),
        .o_ir_write(a_ir), .o_pc_write(a_pc), .o_branch(a_br), .o_uncond_branch(a_ub),
        .o_reg2loc(a_r2l), .o_alu_src(a_src), .o_alu_op(a_aop), .o_mem_read(a_mr),
        .o_mem_write(a_mw), .o_mem_to_reg(a_m2r), .o_reg_write(a_rw), .o_illegal(a_ill),
        .o_instr_count(cnt_a)
    );

    legv8_multicycle_ctrl #(.MEM_LAT(LAT_B), .CNT_W(32)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_im_valid(iv_b), .i_opcode(op_b), .i_zero(zero),
        .o_ir_write(b_ir), .o_pc_write(b_pc), .o_branch(b_br), .o_uncond_branch(b_ub),
        .o_reg2loc(b_r2l), .o_alu_src(b_src), .o_alu_op(b_aop), .o_mem_read(b_mr),
        .o_mem_write(b_mw), .o_mem_to_reg(b_m2r), .o_reg_write(b_rw), .o_illegal(b_ill),
        .o_instr_count(cnt_b)
    );

    assign outs_a = {a_ir, a_pc, a_br, a_ub, a_r2l, a_src, a_aop, a_mr, a_mw, a_m2r, a_rw, a_ill};
    assign outs_b = {b_ir, b_pc, b_br, b_ub, b_r2l, b_src, b_aop, b_mr, b_mw, b_m2r, b_rw, b_ill};

    // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 undecodable
    function automatic int classify(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
        if (op == OP_LDUR) return 1;
        if (op == OP_STUR) return 2;
        if (hi8 == 8'b10110100) return 3;
        if (hi6 == 6'b000101) return 4;
        return 5;
    endfunction

    function automatic logic [10:0] rand_op();
        case ($urandom_range(0, 8))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_ORR;
            4: return OP_LDUR;
            5: return OP_STUR;
            6: return {8'b10110100, 3'($urandom)};
            7: return {6'b000101, 5'($urandom)};
            default: return 11'($urandom);
        endcase
    endfunction

    task automatic build_exp(input logic [10:0] op, input int lat);
        int c;
        c = classify(op);
        exp_q = {};
        exp_q.push_back(O_IR | O_PC);
        exp_q.push_back((c == 2 || c == 3) ? O_R2L : 13'h0);
        case (c)
            0: begin exp_q.push_back(O_A10); exp_q.push_back(O_A10 | O_RW); end
            1: begin
                exp_q.push_back(O_SRC);
                for (int i = 0; i < lat; i++) exp_q.push_back(O_MR | O_SRC);
                exp_q.push_back(O_M2R | O_RW | O_SRC);
            end
            2: begin
                exp_q.push_back(O_SRC);
                for (int i = 0; i < lat; i++) exp_q.push_back(O_MW | O_SRC);
            end
            3: exp_q.push_back(O_R2L | O_A01 | O_BR);
            4: exp_q.push_back(O_UB);
            default: begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
                for (int i = 0; i < 5; i++) exp_q.push_back(O_ILL);
`else
                exp_q.push_back(13'h0);
`endif
            end
        endcase
    endtask

    task automatic drive(input int sel, input logic v, input logic [10:0] op);
        if (sel == 0) begin iv_a = v; op_a = op; end
        else          begin iv_b = v; op_b = op; end
        zero = 1'($urandom);
    endtask

    task automatic check_cycle(input int sel, input logic [12:0] exp_v, input string tag);
        logic [12:0] got, want;
        logic [31:0] gcnt;
        for (int d = 0; d < 2; d++) begin
            got  = (d == 0) ? outs_a : outs_b;
            gcnt = (d == 0) ? cnt_a : cnt_b;
            want = (d == sel) ? exp_v : 13'h0;
            checks++;
            assert (got === want) else begin
                failures++;
                $error("FAIL %s dut%0d outputs got=%h exp=%h", tag, d, got, want);
            end
            checks++;
            assert (gcnt === model_cnt[d]) else begin
                failures++;
                $error("FAIL %s dut%0d instr_count got=%0d exp=%0d", tag, d, gcnt, model_cnt[d]);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b1;
        iv_a = 1'b1;
        iv_b = 1'b1;
        model_cnt[0] = '0;
        model_cnt[1] = '0;
        #1;
        check_cycle(0, 13'h0, tag);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        iv_a = 1'b0;
        iv_b = 1'b0;
    endtask

    task automatic run_instr(input int sel, input logic [10:0] op, input int idle, input string tag);
        for (int i = 0; i < idle; i++) begin
            drive(sel, 1'b0, 11'($urandom));
            @(negedge clk);
            check_cycle(sel, 13'h0, {tag, " idle"});
            @(posedge clk);
            #1;
        end
        build_exp(op, (sel == 0) ? LAT_A : LAT_B);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) drive(sel, 1'b1, op);
            else        drive(sel, 1'($urandom), 11'($urandom));
            @(negedge clk);
            check_cycle(sel, exp_q[k], $sformatf("%s c%0d", tag, k));
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, 11'h0);
`ifdef LEGV8_ILLEGAL_TRAP_EN
        if (classify(op) == 5) begin
            do_reset({tag, " trap-reset"});
            return;
        end
`endif
        model_cnt[sel] = model_cnt[sel] + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] op;
        int          sel;
        model_cnt[0] = '0;
        model_cnt[1] = '0;
        #2;
        do_reset("reset");

        run_instr(0, OP_ADD, 0, "add");
        run_instr(0, OP_LDUR, 0, "ldur_lat3");
        run_instr(1, OP_STUR, 0, "stur_lat1");
        run_instr(0, 11'b10110100101, 0, "cbz");
        run_instr(0, 11'b00010100000, 0, "b");
        run_instr(0, OP_SUB, 5, "idle5_sub");
        run_instr(1, OP_LDUR, 1, "ldur_lat1");
        run_instr(0, OP_STUR, 0, "stur_lat3");
        run_instr(1, OP_ORR, 0, "orr");
        run_instr(0, 11'b00000000000, 0, "illegal");
        run_instr(1, OP_AND, 0, "after_illegal");

        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 1));
            op  = rand_op();
            run_instr(sel, op, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
        end

        // abort a load while MemRead is asserted
        build_exp(OP_LDUR, LAT_A);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(0, 1'b1, OP_LDUR);
            else        drive(0, 1'($urandom), 11'($urandom));
            @(negedge clk);
            check_cycle(0, exp_q[k], $sformatf("abort c%0d", k));
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        do_reset("abort_reset");
        run_instr(0, OP_LDUR, 0, "post_abort");
        run_instr(1, OP_ADD, 0, "post_abort_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
